ped_signal_ctrl_4way: RTL
=========================

PED_SIGNAL_CTRL_4WAY -- requirements
Module: ped_signal_ctrl_4way

Interface
REQ-001 SHALL provide parameter WALK_CYCLES, default 4, cycles of solid WALK per grant (1..15).
REQ-002 SHALL provide parameter CLEAR_CYCLES, default 4, cycles of flashing DONT_WALK after WALK (1..15).
REQ-003 SHALL provide parameter FLASH_HALF, default 1, cycles per flash half-period (1..7).
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-006 SHALL have ports NS_light, EW_light, SN_light, WE_light, input, 2 each, vehicle light codes (00 red, 01 green, 10 yellow, 11 illegal); crosswalk index 0..3 maps to NS, EW, SN, WE.
REQ-007 SHALL have port ped_btn, input, 4, asynchronous pedestrian push-buttons, one per crosswalk.
REQ-008 SHALL have port walk, output, 4, solid WALK indication per crosswalk.
REQ-009 SHALL have port dont_walk, output, 4, DONT_WALK lamp per crosswalk (solid or flashing).
REQ-010 SHALL have port req_pending, output, 4, latched unserved request per crosswalk.

Function
REQ-011 SHALL pass each ped_btn bit through a 2-flop synchronizer, then a rising-edge detector on the synchronized level.
REQ-012 SHALL set req_pending[i] on the edge after a detected rising edge; a held button SHALL NOT generate repeat requests.
REQ-013 SHALL register each light input and detect green entry as current==01 and previous!=01; previous SHALL reset to 00.
REQ-014 SHALL run an independent per-crosswalk FSM with states IDLE, WALK, CLEAR, DONE.
REQ-015 IDLE->WALK SHALL occur only on a green-entry cycle with req_pending[i]=1 or a rising edge detected that same cycle; req_pending[i] SHALL clear on that edge.
REQ-016 A request arriving after green entry SHALL stay pending until the next green entry of that approach.
REQ-017 WALK SHALL last exactly WALK_CYCLES cycles (walk=1, dont_walk=0), then go to CLEAR.
REQ-018 If the approach light leaves 01 during WALK, the FSM SHALL enter CLEAR on the next edge.
REQ-019 CLEAR SHALL last exactly CLEAR_CYCLES cycles (walk=0); dont_walk SHALL be 1 on the first CLEAR cycle and toggle every FLASH_HALF cycles.
REQ-020 If the approach light is 00 or 11 during CLEAR, the FSM SHALL go directly to IDLE on the next edge (safety abort).
REQ-021 CLEAR expiry SHALL go to DONE; DONE SHALL go to IDLE when the approach light is not 01 (one grant per green).
REQ-022 In IDLE and DONE, walk=0 and dont_walk=1.
REQ-023 Code 11 SHALL be treated as red everywhere and SHALL never grant WALK.
REQ-024 Button presses during WALK, CLEAR or DONE SHALL set req_pending for the next green.
REQ-025 All outputs SHALL be registered; walk SHALL rise on the first edge after the green-entry edge.
REQ-026 walk[i] and walk[j] SHALL be allowed simultaneously; no cross-crosswalk arbitration.

Reset
REQ-027 Reset SHALL force all FSMs to IDLE, walk=0000, dont_walk=1111, req_pending=0000, synchronizers, edge detectors, timers and previous-light registers to 0.
REQ-028 Reset asserted mid-WALK/CLEAR SHALL take effect immediately and discard pending requests.

Configuration
REQ-029 With macro PED_COUNTDOWN_EN defined, SHALL add output countdown, 16 bits, nibble i = remaining CLEAR cycles of crosswalk i (CLEAR_CYCLES on first CLEAR cycle, decrementing to 1, 0 outside CLEAR); without it the port and logic SHALL be absent and all other behaviour identical.

Verification
REQ-030 Press btn[0] 5 cycles before NS green entry; NS green 11 cycles -> walk[0]=1 for 4 cycles from entry+1, dont_walk[0] 1,0,1,0 for 4 cycles, then DONE, req_pending[0]=0.
REQ-031 Press btn[1] 2 cycles after EW green entry -> no walk this green; req_pending[1]=1 held; walk[1] asserts after next EW green entry.
REQ-032 Btn[2] rising edge detected on SN green-entry cycle -> grant accepted that green.
REQ-033 WE green shortened to 2 cycles, then yellow then red -> WALK truncated, CLEAR entered, abort to IDLE on first red cycle.
REQ-034 Drive NS_light=11 with pending request -> walk[0] never asserts, dont_walk[0]=1.
REQ-035 Assert reset during CLEAR with PED_COUNTDOWN_EN -> walk=0000, dont_walk=1111, countdown=0, req_pending=0000.

Source files
------------

// File: rtl/ped_signal_ctrl_4way.sv
// Four independent pedestrian crosswalk controllers, each granting one WALK/CLEAR cycle per vehicle green.
// Optional macro PED_COUNTDOWN_EN adds a per-crosswalk CLEAR countdown output.
module ped_signal_ctrl_4way #(
    parameter int WALK_CYCLES  = 4,
    parameter int CLEAR_CYCLES = 4,
    parameter int FLASH_HALF   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  NS_light,
    input  logic [1:0]  EW_light,
    input  logic [1:0]  SN_light,
    input  logic [1:0]  WE_light,
    input  logic [3:0]  ped_btn,
    output logic [3:0]  walk,
    output logic [3:0]  dont_walk,
    output logic [3:0]  req_pending
`ifdef PED_COUNTDOWN_EN
    ,
    output logic [15:0] countdown
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WALK  = 2'd1,
        S_CLEAR = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] WALK_LOAD  = 4'(WALK_CYCLES - 1);
    localparam logic [3:0] CLEAR_LOAD = 4'(CLEAR_CYCLES - 1);
    localparam logic [3:0] CLEAR_INIT = 4'(CLEAR_CYCLES);
    localparam logic [2:0] FLASH_LOAD = 3'(FLASH_HALF - 1);

    logic [1:0] light_in [4];
    assign light_in[0] = NS_light;
    assign light_in[1] = EW_light;
    assign light_in[2] = SN_light;
    assign light_in[3] = WE_light;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_xwalk
            logic       sync1_reg, sync2_reg, btn_prev_reg;
            logic [1:0] light_reg, light_prev_reg;
            state_t     state_reg;
            logic [3:0] timer_reg;
            logic [2:0] flash_reg;
            logic       walk_reg, dont_walk_reg, pend_reg;
            logic       btn_rise, is_green, is_red, green_entry, grant;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sync1_reg      <= 1'b0;
                    sync2_reg      <= 1'b0;
                    btn_prev_reg   <= 1'b0;
                    light_reg      <= 2'b00;
                    light_prev_reg <= 2'b00;
                end else begin
                    sync1_reg      <= ped_btn[gi];
                    sync2_reg      <= sync1_reg;
                    btn_prev_reg   <= sync2_reg;
                    light_reg      <= light_in[gi];
                    light_prev_reg <= light_reg;
                end
            end

            assign btn_rise    = sync2_reg & ~btn_prev_reg;
            assign is_green    = (light_reg == 2'b01);
            // 11 is an illegal code and is handled exactly like red.
            assign is_red      = (light_reg == 2'b00) || (light_reg == 2'b11);
            assign green_entry = is_green && (light_prev_reg != 2'b01);
            assign grant       = (state_reg == S_IDLE) && green_entry && (pend_reg || btn_rise);

`ifdef PED_COUNTDOWN_EN
            logic [3:0] cd_reg;
            assign countdown[gi*4 +: 4] = cd_reg;
`endif

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state_reg     <= S_IDLE;
                    timer_reg     <= 4'd0;
                    flash_reg     <= 3'd0;
                    walk_reg      <= 1'b0;
                    dont_walk_reg <= 1'b1;
                    pend_reg      <= 1'b0;
`ifdef PED_COUNTDOWN_EN
                    cd_reg        <= 4'd0;
`endif
                end else begin
                    // A grant consumes both the latched request and a same-cycle press.
                    if (grant)
                        pend_reg <= 1'b0;
                    else if (btn_rise)
                        pend_reg <= 1'b1;

                    case (state_reg)
                        S_IDLE: begin
                            if (grant) begin
                                state_reg     <= S_WALK;
                                timer_reg     <= WALK_LOAD;
                                walk_reg      <= 1'b1;
                                dont_walk_reg <= 1'b0;
                            end
                        end
                        S_WALK: begin
                            if (!is_green || timer_reg == 4'd0) begin
                                state_reg     <= S_CLEAR;
                                timer_reg     <= CLEAR_LOAD;
                                flash_reg     <= FLASH_LOAD;
                                walk_reg      <= 1'b0;
                                dont_walk_reg <= 1'b1;
`ifdef PED_COUNTDOWN_EN
                                cd_reg        <= CLEAR_INIT;
`endif
                            end else begin
                                timer_reg <= timer_reg - 4'd1;
                            end
                        end
                        S_CLEAR: begin
                            if (is_red || timer_reg == 4'd0) begin
                                state_reg     <= is_red ? S_IDLE : S_DONE;
                                dont_walk_reg <= 1'b1;
`ifdef PED_COUNTDOWN_EN
                                cd_reg        <= 4'd0;
`endif
                            end else begin
                                timer_reg <= timer_reg - 4'd1;
`ifdef PED_COUNTDOWN_EN
                                cd_reg    <= timer_reg;
`endif
                                if (flash_reg == 3'd0) begin
                                    dont_walk_reg <= ~dont_walk_reg;
                                    flash_reg     <= FLASH_LOAD;
                                end else begin
                                    flash_reg <= flash_reg - 3'd1;
                                end
                            end
                        end
                        S_DONE: begin
                            if (!is_green)
                                state_reg <= S_IDLE;
                        end
                        default: state_reg <= S_IDLE;
                    endcase
                end
            end

            assign walk[gi]        = walk_reg;
            assign dont_walk[gi]   = dont_walk_reg;
            assign req_pending[gi] = pend_reg;
        end
    endgenerate

endmodule
